rs_issue_queue: RTL and testbench

Parametrised next-generation reservation station for the out-of-order core. It sits between the ROB/regfile dispatch stage and one functional unit (ALU or ACU).
- Holds DEPTH entries, each with two source operands.
- Wakes operands by snooping CDB_PORTS broadcast ports by tag.
- Issues the oldest ready entry over a valid/ready handshake, replacing fixed-index slot readiness with age-ordered selection and backpressure.

---
 rtl/rs_issue_queue.sv | 233 +++++++++++++++++++++++
 tb/tb_rs_issue_queue.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_issue_queue.sv
// rs_issue_queue: reservation station feeding one functional unit.
// Holds DEPTH entries, snoops CDB_PORTS result buses, issues the oldest ready entry.
//
// Ports:
//   clk, rst (synchronous, active-low), flush (squash all entries)
//   alloc_*  : dispatch side; alloc_ready high while a free entry exists
//   cdb_*    : CDB_PORTS broadcast ports, port p at [p*W +: W]
//   issue_*  : valid/ready payload to the FU, combinational from the entry array
//   num_free : count of free entries
//   stat_*   : full-cycle / issued counters when RS_ISSUE_QUEUE_STATS_EN is defined,
//              otherwise tied to zero
module rs_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int XLEN      = 32,
    parameter int TAG_W     = 4,
    parameter int OP_W      = 5,
    parameter int CDB_PORTS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [TAG_W-1:0]           alloc_tag,
    input  logic [OP_W-1:0]            alloc_op,
    input  logic                       alloc_busy1,
    input  logic [XLEN-1:0]            alloc_src1,
    input  logic                       alloc_busy2,
    input  logic [XLEN-1:0]            alloc_src2,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]  cdb_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [TAG_W-1:0]           issue_tag,
    output logic [OP_W-1:0]            issue_op,
    output logic [XLEN-1:0]            issue_src1,
    output logic [XLEN-1:0]            issue_src2,
    output logic [$clog2(DEPTH):0]     num_free,
    output logic [31:0]                stat_full_cycles,
    output logic [31:0]                stat_issued
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_busy1;
    logic [DEPTH-1:0] e_busy2;
    logic [XLEN-1:0]  e_src1 [DEPTH];
    logic [XLEN-1:0]  e_src2 [DEPTH];
    logic [TAG_W-1:0] e_tag  [DEPTH];
    logic [OP_W-1:0]  e_op   [DEPTH];
    // older[i][j] set: entry i was allocated before entry j
    logic [DEPTH-1:0] older  [DEPTH];

    logic             lock_valid;
    logic [IDX_W-1:0] lock_idx;

    logic [DEPTH-1:0] ready;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] issue_idx;
    logic             free_found;
    logic [IDX_W-1:0] alloc_idx;
    logic [CNT_W-1:0] free_cnt;
    logic             alloc_fire;
    logic             issue_fire;

    logic             w_busy1 [DEPTH];
    logic             w_busy2 [DEPTH];
    logic [XLEN-1:0]  w_src1  [DEPTH];
    logic [XLEN-1:0]  w_src2  [DEPTH];
    logic             a_busy1;
    logic             a_busy2;
    logic [XLEN-1:0]  a_src1;
    logic [XLEN-1:0]  a_src2;

    assign ready = e_valid & ~e_busy1 & ~e_busy2;

    // Oldest ready entry: ready and no other ready entry is older
    always_comb begin
        logic blk;
        sel_found = 1'b0;
        sel_idx   = '0;
        blk       = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blk = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && older[j][i]) blk = 1'b1;
            end
            if (ready[i] && !blk && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // A locked selection is held until the FU takes it
    assign issue_idx   = lock_valid ? lock_idx : sel_idx;
    assign issue_valid = lock_valid | sel_found;
    assign issue_tag   = e_tag[issue_idx];
    assign issue_op    = e_op[issue_idx];
    assign issue_src1  = e_src1[issue_idx];
    assign issue_src2  = e_src2[issue_idx];

    always_comb begin
        free_found = 1'b0;
        alloc_idx  = '0;
        free_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_cnt = free_cnt + {{(CNT_W-1){1'b0}}, ~e_valid[i]};
            if (!e_valid[i] && !free_found) begin
                free_found = 1'b1;
                alloc_idx  = IDX_W'(i);
            end
        end
    end

    assign num_free    = free_cnt;
    assign alloc_ready = (free_cnt != '0);
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign issue_fire  = issue_valid & issue_ready;

    // Wakeup: the first matching port clears busy, so lowest port wins
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_busy1[i] = e_busy1[i];
            w_busy2[i] = e_busy2[i];
            w_src1[i]  = e_src1[i];
            w_src2[i]  = e_src2[i];
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (w_busy1[i] && cdb_valid[p] &&
                    cdb_tag[p*TAG_W +: TAG_W] == e_src1[i][TAG_W-1:0]) begin
                    w_busy1[i] = 1'b0;
                    w_src1[i]  = cdb_data[p*XLEN +: XLEN];
                end
                if (w_busy2[i] && cdb_valid[p] &&
                    cdb_tag[p*TAG_W +: TAG_W] == e_src2[i][TAG_W-1:0]) begin
                    w_busy2[i] = 1'b0;
                    w_src2[i]  = cdb_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    // Same-cycle bypass of a broadcast into the entry being allocated
    always_comb begin
        a_busy1 = alloc_busy1;
        a_busy2 = alloc_busy2;
        a_src1  = alloc_src1;
        a_src2  = alloc_src2;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (a_busy1 && cdb_valid[p] &&
                cdb_tag[p*TAG_W +: TAG_W] == alloc_src1[TAG_W-1:0]) begin
                a_busy1 = 1'b0;
                a_src1  = cdb_data[p*XLEN +: XLEN];
            end
            if (a_busy2 && cdb_valid[p] &&
                cdb_tag[p*TAG_W +: TAG_W] == alloc_src2[TAG_W-1:0]) begin
                a_busy2 = 1'b0;
                a_src2  = cdb_data[p*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            e_valid    <= '0;
            e_busy1    <= '0;
            e_busy2    <= '0;
            lock_valid <= 1'b0;
            lock_idx   <= '0;
        end else if (flush) begin
            e_valid    <= '0;
            lock_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i]) begin
                    e_busy1[i] <= w_busy1[i];
                    e_busy2[i] <= w_busy2[i];
                    e_src1[i]  <= w_src1[i];
                    e_src2[i]  <= w_src2[i];
                end
            end
            if (issue_fire) begin
                e_valid[issue_idx] <= 1'b0;
                lock_valid         <= 1'b0;
            end else if (issue_valid) begin
                lock_valid <= 1'b1;
                lock_idx   <= issue_idx;
            end
            // Allocation targets an entry that was free, so it never
            // collides with the issued entry above
            if (alloc_fire) begin
                e_valid[alloc_idx] <= 1'b1;
                e_busy1[alloc_idx] <= a_busy1;
                e_busy2[alloc_idx] <= a_busy2;
                e_src1[alloc_idx]  <= a_src1;
                e_src2[alloc_idx]  <= a_src2;
                e_tag[alloc_idx]   <= alloc_tag;
                e_op[alloc_idx]    <= alloc_op;
                for (int j = 0; j < DEPTH; j++) begin
                    older[alloc_idx][j] <= 1'b0;
                    older[j][alloc_idx] <= 1'b1;
                end
            end
        end
    end

`ifdef RS_ISSUE_QUEUE_STATS_EN
    logic [31:0] full_q;
    logic [31:0] iss_q;

    // Counters survive flush; only reset clears them
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= '0;
            iss_q  <= '0;
        end else begin
            if (free_cnt == '0 && full_q != 32'hFFFF_FFFF) full_q <= full_q + 32'd1;
            if (issue_fire && !flush && iss_q != 32'hFFFF_FFFF) iss_q <= iss_q + 32'd1;
        end
    end

    assign stat_full_cycles = full_q;
    assign stat_issued      = iss_q;
`else
    assign stat_full_cycles = '0;
    assign stat_issued      = '0;
`endif

endmodule

// File: tb/tb_rs_issue_queue.sv
// tb_rs_issue_queue: directed self-checking bench for rs_issue_queue.
// Default parameters; stats expectations follow RS_ISSUE_QUEUE_STATS_EN.
module tb_rs_issue_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic [4:0]  alloc_op;
    logic        alloc_busy1;
    logic [31:0] alloc_src1;
    logic        alloc_busy2;
    logic [31:0] alloc_src2;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_tag;
    logic [4:0]  issue_op;
    logic [31:0] issue_src1;
    logic [31:0] issue_src2;
    logic [3:0]  num_free;
    logic [31:0] stat_full_cycles;
    logic [31:0] stat_issued;

    int checks = 0;
    int errors = 0;

`ifdef RS_ISSUE_QUEUE_STATS_EN
    localparam logic [31:0] EXP_FULL = 32'd10;
    localparam logic [31:0] EXP_ISS  = 32'd4;
`else
    localparam logic [31:0] EXP_FULL = 32'd0;
    localparam logic [31:0] EXP_ISS  = 32'd0;
`endif

    rs_issue_queue dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .alloc_valid      (alloc_valid),
        .alloc_ready      (alloc_ready),
        .alloc_tag        (alloc_tag),
        .alloc_op         (alloc_op),
        .alloc_busy1      (alloc_busy1),
        .alloc_src1       (alloc_src1),
        .alloc_busy2      (alloc_busy2),
        .alloc_src2       (alloc_src2),
        .cdb_valid        (cdb_valid),
        .cdb_tag          (cdb_tag),
        .cdb_data         (cdb_data),
        .issue_valid      (issue_valid),
        .issue_ready      (issue_ready),
        .issue_tag        (issue_tag),
        .issue_op         (issue_op),
        .issue_src1       (issue_src1),
        .issue_src2       (issue_src2),
        .num_free         (num_free),
        .stat_full_cycles (stat_full_cycles),
        .stat_issued      (stat_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [3:0] t, input logic b1, input logic [31:0] s1,
                         input logic b2, input logic [31:0] s2);
        alloc_valid = 1'b1;
        alloc_tag   = t;
        alloc_op    = {1'b0, t};
        alloc_busy1 = b1;
        alloc_src1  = s1;
        alloc_busy2 = b2;
        alloc_src2  = s2;
    endtask

    task automatic cdb(input logic [1:0] v, input logic [3:0] t0, input logic [31:0] d0,
                       input logic [3:0] t1, input logic [31:0] d1);
        cdb_valid = v;
        cdb_tag   = {t1, t0};
        cdb_data  = {d1, d0};
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; alloc_valid = 1'b0; alloc_tag = '0; alloc_op = '0;
        alloc_busy1 = 1'b0; alloc_src1 = '0; alloc_busy2 = 1'b0; alloc_src2 = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
        tick(); tick();
        chk("rst_num_free", 32'(num_free), 32'd8);
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_stat_full", stat_full_cycles, 32'd0);
        chk("rst_stat_issued", stat_issued, 32'd0);
        rst = 1'b1;
        tick();

        // Three ready entries stream out in order
        issue_ready = 1'b1;
        alloc(4'd1, 1'b0, 32'h11, 1'b0, 32'h12);
        tick();
        chk("t1_v1", 32'(issue_valid), 32'd1);
        chk("t1_tag1", 32'(issue_tag), 32'd1);
        chk("t1_src1", issue_src1, 32'h11);
        chk("t1_src2", issue_src2, 32'h12);
        chk("t1_nf1", 32'(num_free), 32'd7);
        alloc(4'd2, 1'b0, 32'h21, 1'b0, 32'h22);
        tick();
        chk("t1_tag2", 32'(issue_tag), 32'd2);
        chk("t1_op2", 32'(issue_op), 32'd2);
        chk("t1_nf2", 32'(num_free), 32'd7);
        alloc(4'd3, 1'b0, 32'h31, 1'b0, 32'h32);
        tick();
        chk("t1_tag3", 32'(issue_tag), 32'd3);
        chk("t1_src1_3", issue_src1, 32'h31);
        alloc_valid = 1'b0;
        tick();
        chk("t1_nf_end", 32'(num_free), 32'd8);
        chk("t1_v_end", 32'(issue_valid), 32'd0);

        // Wakeup from port 1, issue one cycle after the broadcast
        alloc(4'd5, 1'b1, 32'd9, 1'b0, 32'h55);
        tick();
        alloc_valid = 1'b0;
        chk("t2_wait", 32'(issue_valid), 32'd0);
        cdb(2'b10, 4'd0, 32'h0, 4'd9, 32'hDEAD_BEEF);
        tick();
        cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        chk("t2_v", 32'(issue_valid), 32'd1);
        chk("t2_tag", 32'(issue_tag), 32'd5);
        chk("t2_src1", issue_src1, 32'hDEAD_BEEF);
        chk("t2_src2", issue_src2, 32'h55);
        tick();
        chk("t2_nf", 32'(num_free), 32'd8);

        // Same-cycle bypass on allocation
        alloc(4'd8, 1'b0, 32'hA1, 1'b1, 32'd7);
        cdb(2'b01, 4'd7, 32'h1234, 4'd0, 32'h0);
        tick();
        alloc_valid = 1'b0;
        cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        chk("t3_v", 32'(issue_valid), 32'd1);
        chk("t3_tag", 32'(issue_tag), 32'd8);
        chk("t3_src2", issue_src2, 32'h1234);
        tick();
        chk("t3_nf", 32'(num_free), 32'd8);

        // Low-tag-bit compare, both ports match: port 0 wins
        issue_ready = 1'b0;
        alloc(4'd10, 1'b1, 32'hFFFF_FFF3, 1'b1, 32'h0000_0013);
        tick();
        alloc_valid = 1'b0;
        chk("t3b_wait", 32'(issue_valid), 32'd0);
        cdb(2'b11, 4'd3, 32'hA0A0, 4'd3, 32'hB0B0);
        tick();
        cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        chk("t3b_v", 32'(issue_valid), 32'd1);
        chk("t3b_src1", issue_src1, 32'hA0A0);
        chk("t3b_src2", issue_src2, 32'hA0A0);
        issue_ready = 1'b1;
        tick();
        chk("t3b_nf", 32'(num_free), 32'd8);

        // Two sources woken by different ports in one cycle
        issue_ready = 1'b0;
        alloc(4'd11, 1'b1, 32'd4, 1'b1, 32'd5);
        tick();
        alloc_valid = 1'b0;
        cdb(2'b11, 4'd5, 32'h50, 4'd4, 32'h40);
        tick();
        cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        chk("t3c_v", 32'(issue_valid), 32'd1);
        chk("t3c_src1", issue_src1, 32'h40);
        chk("t3c_src2", issue_src2, 32'h50);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;

        // Fresh stats, then fill, lock and release
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 0)      alloc(4'd0, 1'b1, 32'd12, 1'b0, 32'h200);
            else if (k == 1) alloc(4'd1, 1'b1, 32'd13, 1'b0, 32'h201);
            else             alloc(4'(k), 1'b0, 32'h100 + k, 1'b0, 32'h200 + k);
            tick();
        end
        chk("t4_full_nf", 32'(num_free), 32'd0);
        chk("t4_full_ar", 32'(alloc_ready), 32'd0);
        chk("t4_sel_tag", 32'(issue_tag), 32'd2);
        alloc(4'd14, 1'b0, 32'hEE, 1'b0, 32'hEE);
        tick();
        alloc_valid = 1'b0;
        chk("t4_extra_nf", 32'(num_free), 32'd0);
        cdb(2'b01, 4'd12, 32'hC0, 4'd0, 32'h0);
        tick();
        cdb(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        chk("t4_lock_tag", 32'(issue_tag), 32'd2);
        chk("t4_lock_src1", issue_src1, 32'h102);
        for (int k = 0; k < 7; k++) tick();
        chk("t4_hold_tag", 32'(issue_tag), 32'd2);
        chk("t4_hold_v", 32'(issue_valid), 32'd1);
        issue_ready = 1'b1;
        tick();
        chk("t4_old_tag", 32'(issue_tag), 32'd0);
        chk("t4_old_src1", issue_src1, 32'hC0);
        chk("t4_nf1", 32'(num_free), 32'd1);
        tick();
        chk("t4_next3", 32'(issue_tag), 32'd3);
        tick();
        chk("t4_next4", 32'(issue_tag), 32'd4);
        tick();
        chk("t4_next5", 32'(issue_tag), 32'd5);
        chk("t4_stat_full", stat_full_cycles, EXP_FULL);
        chk("t4_stat_iss", stat_issued, EXP_ISS);
        issue_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_nf", 32'(num_free), 32'd8);

        // Flush with a concurrent alloc and accept
        for (int k = 0; k < 6; k++) begin
            alloc(4'(k), 1'b0, 32'h300 + k, 1'b0, 32'h400 + k);
            tick();
        end
        chk("t5_nf6", 32'(num_free), 32'd2);
        alloc(4'd9, 1'b0, 32'h99, 1'b0, 32'h99);
        issue_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        alloc_valid = 1'b0;
        issue_ready = 1'b0;
        chk("t5_nf", 32'(num_free), 32'd8);
        chk("t5_v", 32'(issue_valid), 32'd0);
        tick();
        chk("t5_nf_after", 32'(num_free), 32'd8);
        chk("t5_v_after", 32'(issue_valid), 32'd0);
        chk("t5_stat_full", stat_full_cycles, EXP_FULL);
        chk("t5_stat_iss", stat_issued, EXP_ISS);

        // Reset in the middle of a stalled handshake
        alloc(4'd6, 1'b0, 32'h66, 1'b0, 32'h67);
        tick();
        alloc_valid = 1'b0;
        tick();
        chk("t6_pre_v", 32'(issue_valid), 32'd1);
        rst = 1'b0;
        tick();
        chk("t6_nf", 32'(num_free), 32'd8);
        chk("t6_ar", 32'(alloc_ready), 32'd1);
        chk("t6_v", 32'(issue_valid), 32'd0);
        chk("t6_stat_full", stat_full_cycles, 32'd0);
        chk("t6_stat_iss", stat_issued, 32'd0);
        rst = 1'b1;
        tick();
        chk("t6_v_after", 32'(issue_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
